// File: rtl/audio_pkg.sv
// Shared types and defaults for the codec audio path.
package audio_pkg;

    localparam int AUDIO_WORD_LENGTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        WAIT
    } rx_state_t;

    typedef enum logic {
        CH_LEFT,
        CH_RIGHT
    } channel_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin followed by a registered
// edge detector; rise/fall are single-clk strobes 3 clk after the pin edge.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       last_reg;
    logic       rise_reg;
    logic       fall_reg;

    // Synchronize the pin, then compare against the previous synchronized level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], pin};
            last_reg <= sync_reg[1];
            rise_reg <= sync_reg[1] & ~last_reg;
            fall_reg <= ~sync_reg[1] & last_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/i2s_frame_receiver.sv
// Oversampling I2S / left-justified receiver: deserializes one left and one
// right word per LRCK frame and offers them as a pair on valid/ready.
module i2s_frame_receiver
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH = AUDIO_WORD_LENGTH,
    parameter int I2S_DELAY   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   aud_bclk,
    input  logic                   aud_lrck,
    input  logic                   aud_adcdat,
    input  logic                   sample_ready,
    output logic [WORD_LENGTH-1:0] sample_left,
    output logic [WORD_LENGTH-1:0] sample_right,
    output logic                   sample_valid,
    output logic                   overrun,
    output logic                   short_frame
);

    localparam int CNT_W  = $clog2(WORD_LENGTH + 1);
    localparam int SKIP_W = (I2S_DELAY > 1) ? $clog2(I2S_DELAY) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_LENGTH - 1);
    localparam logic [SKIP_W-1:0] LAST_SKIP = SKIP_W'((I2S_DELAY > 0) ? I2S_DELAY - 1 : 0);

    logic bclk_rise, unused_bclk_fall, lrck_rise, lrck_fall;
    logic [2:0] adcdat_pipe_reg;
    logic       data_bit;

    rx_state_t              state_reg, state_next;
    channel_t               channel_reg, channel_next;
    logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [SKIP_W-1:0]      skip_cnt_reg, skip_cnt_next;
    logic [WORD_LENGTH-2:0] shift_reg, shift_next;
    logic [WORD_LENGTH-1:0] left_hold_reg, left_hold_next;
    logic [WORD_LENGTH-1:0] shifted;
    logic                   pair_done, short_hit, start_frame;

    logic [WORD_LENGTH-1:0] sample_left_reg, sample_right_reg;
    logic                   sample_valid_reg, overrun_reg, short_frame_reg;

    sync_edge_detect u_bclk_edge (
        .clk   (clk),
        .reset (reset),
        .pin   (aud_bclk),
        .rise  (bclk_rise),
        .fall  (unused_bclk_fall)
    );

    sync_edge_detect u_lrck_edge (
        .clk   (clk),
        .reset (reset),
        .pin   (aud_lrck),
        .rise  (lrck_rise),
        .fall  (lrck_fall)
    );

    // Data takes three stages so it lines up with the registered BCLK strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            adcdat_pipe_reg <= '0;
        end else begin
            adcdat_pipe_reg <= {adcdat_pipe_reg[1:0], aud_adcdat};
        end
    end

    assign data_bit = adcdat_pipe_reg[2];

    // Frame FSM: channel tracking, delay skip, bit shifting and frame checks.
    always_comb begin
        state_next     = state_reg;
        channel_next   = channel_reg;
        bit_cnt_next   = bit_cnt_reg;
        skip_cnt_next  = skip_cnt_reg;
        shift_next     = shift_reg;
        left_hold_next = left_hold_reg;
        pair_done      = 1'b0;
        short_hit      = 1'b0;
        start_frame    = 1'b0;
        shifted        = {shift_reg, data_bit};

        case (state_reg)
            IDLE: begin
                if (lrck_fall) begin
                    start_frame  = 1'b1;
                    channel_next = CH_LEFT;
                end
            end
            SKIP, SHIFT: begin
                if (lrck_fall || lrck_rise) begin
                    // Channel ended early: the whole frame is worthless.
                    short_hit      = 1'b1;
                    left_hold_next = '0;
                    if (lrck_fall) begin
                        start_frame  = 1'b1;
                        channel_next = CH_LEFT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bclk_rise) begin
                    if (state_reg == SKIP) begin
                        if (skip_cnt_reg == LAST_SKIP) begin
                            state_next = SHIFT;
                        end else begin
                            skip_cnt_next = skip_cnt_reg + 1'b1;
                        end
                    end else begin
                        shift_next   = shifted[WORD_LENGTH-2:0];
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = WAIT;
                            if (channel_reg == CH_LEFT) begin
                                left_hold_next = shifted;
                            end else begin
                                pair_done = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                if (lrck_rise) begin
                    if (channel_reg == CH_LEFT) begin
                        start_frame  = 1'b1;
                        channel_next = CH_RIGHT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (lrck_fall) begin
                    if (channel_reg == CH_RIGHT) begin
                        start_frame  = 1'b1;
                        channel_next = CH_LEFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_frame) begin
            skip_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = (I2S_DELAY == 0) ? SHIFT : SKIP;
            // Left-justified: a BCLK rise landing with the LRCK edge is the MSB.
            if (I2S_DELAY == 0 && bclk_rise) begin
                shift_next   = shifted[WORD_LENGTH-2:0];
                bit_cnt_next = CNT_W'(1);
            end
        end

        if (!enable) begin
            state_next = IDLE;
            pair_done  = 1'b0;
            short_hit  = 1'b0;
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            channel_reg   <= CH_LEFT;
            bit_cnt_reg   <= '0;
            skip_cnt_reg  <= '0;
            shift_reg     <= '0;
            left_hold_reg <= '0;
        end else begin
            state_reg     <= state_next;
            channel_reg   <= channel_next;
            bit_cnt_reg   <= bit_cnt_next;
            skip_cnt_reg  <= skip_cnt_next;
            shift_reg     <= shift_next;
            left_hold_reg <= left_hold_next;
        end
    end

    // One-deep output buffer with overrun detection and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_left_reg  <= '0;
            sample_right_reg <= '0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            short_frame_reg  <= 1'b0;
        end else begin
            overrun_reg     <= 1'b0;
            short_frame_reg <= short_hit;
            if (pair_done) begin
                if (sample_valid_reg && !sample_ready) begin
                    overrun_reg <= 1'b1;
                end else begin
                    sample_left_reg  <= left_hold_reg;
                    sample_right_reg <= shifted;
                    sample_valid_reg <= 1'b1;
                end
            end else if (sample_valid_reg && sample_ready) begin
                sample_valid_reg <= 1'b0;
            end
        end
    end

    assign sample_left  = sample_left_reg;
    assign sample_right = sample_right_reg;
    assign sample_valid = sample_valid_reg;
    assign overrun      = overrun_reg;
    assign short_frame  = short_frame_reg;

endmodule

// File: doc/i2s_frame_receiver.md
# i2s_frame_receiver

Oversampling I2S receiver for the codec ADC path: takes the raw BCLK/LRCK/ADCDAT pins into the system clock domain, deserializes one left and one right word per LRCK frame, and presents them as a stereo pair on a valid/ready handshake. It is the receiving counterpart of the serial send register on the DAC side, and it feeds the filter bank in place of the free-running per-channel shift registers. It also flags overruns and short words.

## Interface
Parameters:
- WORD_LENGTH, 16, bits captured per channel, MSB first.
- I2S_DELAY, 1, BCLK periods between an LRCK edge and the MSB (1 = I2S, 0 = left-justified).

Ports:
- clk  input  1  system clock, at least 4× the BCLK frequency.
- reset  input  1  synchronous, active-high.
- enable  input  1  when low, FSM is forced to IDLE at the next clk and no new pair is produced.
- aud_bclk  input  1  codec bit clock, asynchronous to clk.
- aud_lrck  input  1  codec LR clock, asynchronous; low = left, high = right.
- aud_adcdat  input  1  codec serial ADC data, asynchronous.
- sample_ready  input  1  consumer accepts the pair.
- sample_left  output  WORD_LENGTH  left word, two's complement.
- sample_right  output  WORD_LENGTH  right word from the same frame.
- sample_valid  output  1  pair available.
- overrun  output  1  1-clk pulse: a completed pair was dropped.
- short_frame  output  1  1-clk pulse: LRCK toggled before WORD_LENGTH bits were captured.

## Operation
- **Input synchronizers.** All three pins pass through 2-FF synchronizers with identical delay, so the data stays aligned with its BCLK.
- **Edge detection.** A registered edge detector produces these 1-clk strobes: bclk_rise, lrck_fall, lrck_rise.
- **Bit sampling.** Data is sampled only on bclk_rise.
- **FSM** (rx_state_t):
  - IDLE: wait for lrck_fall, then go to SKIP with channel = left.
  - SKIP: count I2S_DELAY bclk_rise events, then go to SHIFT. With I2S_DELAY = 0, lrck_fall goes directly to SHIFT, and the bclk_rise coinciding with the LRCK edge captures the MSB.
  - SHIFT: on each bclk_rise, shift the bit in at the LSB of the shift register and increment bit_cnt. When bit_cnt reaches WORD_LENGTH:
    - left channel: store the word in the left holding register, then go to WAIT.
    - right channel: the pair is complete; go to WAIT.
  - WAIT: ignore further bclk_rise events. lrck_rise (after left) selects channel = right and goes to SKIP. lrck_fall (after right) selects channel = left and goes to SKIP.
- **Short word.** An LRCK edge while in SHIFT pulses short_frame and discards the partial frame, including any stored left word. A lrck_fall restarts at left; a lrck_rise returns to IDLE.
- **Out-of-order LRCK edge.** An LRCK edge arriving in WAIT out of order (for example lrck_fall while in left WAIT) returns the FSM to IDLE. No flag is raised.
- **Output buffer.** The output is a one-deep buffer:
  - A completed pair loads sample_left and sample_right and sets sample_valid.
  - sample_valid stays high, with both data outputs stable, until sample_valid && sample_ready.
- **Overrun.** If a pair completes while sample_valid is high and sample_ready is low, overrun pulses, the new pair is dropped, and the old pair is retained.
- **Completion and handshake in the same clk.** The old pair is consumed, the new pair is loaded, and sample_valid stays high. No overrun is raised.
- **Enable low mid-frame.** The partial frame is discarded silently. A pending output pair is kept.
- **Reset.** All outputs go to 0, the FSM goes to IDLE, and bit_cnt and the shift register are cleared. A reset applied mid-frame discards everything, including a pending pair.

## Timing
- Pin-to-strobe latency: 3 clk (2 synchronizer stages plus 1 edge register).
- sample_valid rises 1 clk after the bclk_rise strobe that captures the right-channel LSB. Worst-case latency from the pin edge is 4 clk.
- overrun and short_frame assert in the same clk as the offending strobe's effect, i.e. 1 clk after that strobe. Each lasts exactly 1 clk.
- Throughput: one pair per LRCK period. The handshake never stalls capture.

## Structure
- Package audio_pkg contains:
  - rx_state_t enum {IDLE, SKIP, SHIFT, WAIT}
  - channel_t enum {CH_LEFT, CH_RIGHT}
  - the default AUDIO_WORD_LENGTH = 16
- Sub-module sync_edge_detect: 2-FF synchronizer plus rise/fall strobes. It is instantiated for bclk and lrck. adcdat uses only the synchronizer output, with matched delay.

## Test plan
- I2S frame, 32 BCLK per channel, clk = 8× BCLK, left = 16'h8001, right = 16'h7FFE, sample_ready high -> one sample_valid pulse with sample_left = 16'h8001 and sample_right = 16'h7FFE. overrun and short_frame stay 0.
- sample_ready held low across two frames (pairs 16'h1111/16'h2222, then 16'h3333/16'h4444) -> outputs hold 16'h1111/16'h2222, overrun pulses once at the second completion, then raising sample_ready delivers 16'h1111/16'h2222 only.
- LRCK toggles after 10 bits of the left word -> short_frame pulses once, no pair is produced, and the next full frame 16'hA5A5/16'h5A5A is delivered correctly.
- I2S_DELAY = 0, left-justified frame with 16'hFFFF/16'h0000 -> exact values captured, no bit shift.
- reset asserted on the 8th right-channel bit with a pending pair held -> next clk all outputs are 0, FSM is IDLE, and the first full frame after reset is delivered correctly.
- sample_ready is 1 in the same clk that the next pair completes -> the consumer sees both pairs back to back, sample_valid stays high, and overrun stays 0.
